// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus console FIFO, cycle counter and HALT MMIO.
// Define DMEM_LOADER_EN to add the host preload port (ld_en/ld_addr/ld_wdata).
module dmem_responder #(
  parameter int WIDTH      = 32,
  parameter int DADDR      = 16,
  parameter int MEM_WORDS  = 4096,
  parameter int FIFO_DEPTH = 16,
  parameter logic [DADDR-1:0] MMIO_BASE = 16'hFF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DADDR-1:0] dmem_addr,
  input  logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_wr_en,
  output logic [WIDTH-1:0] dmem_rdata,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
`ifdef DMEM_LOADER_EN
  input  logic             ld_en,
  input  logic [DADDR-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_wdata,
`endif
  output logic             halt,
  output logic [WIDTH-1:0] halt_code
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [DADDR:0] RAM_LIM = (DADDR+1)'(MEM_WORDS*4);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [MEM_WORDS];
  logic [7:0]       fifo_q [FIFO_DEPTH];

  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             halt_q, halt_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [31:0]      cyc_q, cyc_d;

  logic [DADDR-1:0] a, moff;
  logic             is_ram, is_mmio;
  logic [1:0]       reg_sel;
  logic [AW-1:0]    ridx;
  logic             wr_tx, wr_stat, wr_halt;
  logic             full, empty, pop, push_ok;
  logic [31:0]      stat_w;
  logic             unused_addr_lsb;

  assign a       = {dmem_addr[DADDR-1:2], 2'b00};
  assign moff    = a - MMIO_BASE;
  assign is_ram  = {1'b0, a} < RAM_LIM;
  assign is_mmio = (a >= MMIO_BASE) && (moff < DADDR'(16));
  assign reg_sel = moff[3:2];
  assign ridx    = a[AW+1:2];
  assign unused_addr_lsb = ^dmem_addr[1:0];

  assign wr_tx   = dmem_wr_en && is_mmio && (reg_sel == 2'd0);
  assign wr_stat = dmem_wr_en && is_mmio && (reg_sel == 2'd1);
  assign wr_halt = dmem_wr_en && is_mmio && (reg_sel == 2'd3);

  // Single RAM write port; the host loader takes it over the core.
  logic             ram_we;
  logic [AW-1:0]    ram_widx;
  logic [WIDTH-1:0] ram_wdat;
`ifdef DMEM_LOADER_EN
  logic [DADDR-1:0] la;
  logic             ld_ram;
  logic             unused_ld_lsb;
  assign la       = {ld_addr[DADDR-1:2], 2'b00};
  assign ld_ram   = ld_en && ({1'b0, la} < RAM_LIM);
  assign unused_ld_lsb = ^ld_addr[1:0];
  assign ram_we   = ld_ram || (dmem_wr_en && is_ram);
  assign ram_widx = ld_ram ? la[AW+1:2] : ridx;
  assign ram_wdat = ld_ram ? ld_wdata : dmem_wdata;
`else
  assign ram_we   = dmem_wr_en && is_ram;
  assign ram_widx = ridx;
  assign ram_wdat = dmem_wdata;
`endif

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_widx] <= ram_wdat;
  end

  assign full     = (cnt_q == CNT_FULL);
  assign empty    = (cnt_q == '0);
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[rd_q];
  assign pop      = tx_valid && tx_ready;
  // A pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = wr_tx && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok && !reset) fifo_q[wr_q] <= dmem_wdata[7:0];
  end

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    halt_d = halt_q;
    code_d = code_q;
    cyc_d  = cyc_q + 32'd1;
    if (pop) rd_d = rd_q + 1'b1;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (push_ok && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push_ok) cnt_d = cnt_q - 1'b1;
    if (wr_tx && !push_ok) ovf_d = 1'b1;
    else if (wr_stat && dmem_wdata[2]) ovf_d = 1'b0;
    if (wr_halt) begin
      halt_d = 1'b1;
      code_d = dmem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      halt_q <= 1'b0;
      code_q <= '0;
      cyc_q  <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      halt_q <= halt_d;
      code_q <= code_d;
      cyc_q  <= cyc_d;
    end
  end

  assign halt      = halt_q;
  assign halt_code = code_q;
  assign stat_w    = {16'h0, 8'(cnt_q), 5'h0, ovf_q, empty, full};

  always_comb begin
    dmem_rdata = '0;
    unique case (1'b1)
      is_ram: dmem_rdata = mem_q[ridx];
      is_mmio: begin
        case (reg_sel)
          2'd1:    dmem_rdata = WIDTH'(stat_w);
          2'd2:    dmem_rdata = WIDTH'(cyc_q);
          2'd3:    dmem_rdata = code_q;
          default: dmem_rdata = '0;
        endcase
      end
      default: dmem_rdata = '0;
    endcase
  end

endmodule
